render_number_ctrl: RTL

RENDER_NUMBER_CTRL -- requirements
Module: render_number_ctrl

---
 rtl/render_pkg.sv | 18 +
 rtl/bin2bcd_seq.sv | 75 +++++++
 rtl/render_number_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/render_pkg.sv
// Shared constants and FSM encoding for the number-rendering sequencer.
package render_pkg;
    localparam int GLYPH_W   = 12;
    localparam int GLYPH_H   = 18;
    localparam int GLYPH_PIX = GLYPH_W * GLYPH_H;
    localparam int BCD_W     = 4;
    localparam int VALUE_W   = 14;
    localparam int POS_W     = 10;
    localparam int ADDR_W    = 12;

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        ISSUE,
        WAIT,
        FIN
    } state_t;
endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary to BCD converter, one input bit per cycle.
module bin2bcd_seq #(
    parameter int IN_W   = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [IN_W-1:0]       din,
    output logic                  busy,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd
);
    import render_pkg::*;

    localparam int OUT_W = BCD_W * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);

    logic [IN_W-1:0]  shift_reg;
    logic [OUT_W-1:0] bcd_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;
    logic             valid_reg;

    logic             load;
    logic             bit_in;
    logic [OUT_W-1:0] bcd_src;
    logic [OUT_W-1:0] bcd_adj;
    logic [OUT_W-1:0] bcd_next;

    // The first shift happens on the load edge itself, so IN_W steps take IN_W cycles.
    assign load    = start && !busy_reg;
    assign bcd_src = load ? '0 : bcd_reg;
    assign bit_in  = load ? din[IN_W-1] : shift_reg[IN_W-1];

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign bcd_adj[gi*BCD_W +: BCD_W] =
                (bcd_src[gi*BCD_W +: BCD_W] >= 4'd5) ? bcd_src[gi*BCD_W +: BCD_W] + 4'd3
                                                     : bcd_src[gi*BCD_W +: BCD_W];
        end
    endgenerate

    assign bcd_next = {bcd_adj[OUT_W-2:0], bit_in};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift_reg <= '0;
            bcd_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            if (load) begin
                shift_reg <= din << 1;
                bcd_reg   <= bcd_next;
                cnt_reg   <= CNT_W'(1);
                busy_reg  <= 1'b1;
            end else if (busy_reg) begin
                shift_reg <= shift_reg << 1;
                bcd_reg   <= bcd_next;
                cnt_reg   <= cnt_reg + 1'b1;
                if (cnt_reg == CNT_W'(IN_W - 1)) begin
                    busy_reg  <= 1'b0;
                    valid_reg <= 1'b1;
                end
            end
        end
    end

    assign busy  = busy_reg;
    assign valid = valid_reg;
    assign bcd   = bcd_reg;
endmodule

// File: rtl/render_number_ctrl.sv
// Sequences a per-digit glyph renderer to draw a saturated decimal number,
// optionally suppressing leading zeros while keeping digits right-aligned.
module render_number_ctrl #(
    parameter int DIGITS    = 4,
    parameter int GLYPH_W   = render_pkg::GLYPH_W,
    parameter int GLYPH_PIX = render_pkg::GLYPH_PIX
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            start,
    input  logic [render_pkg::VALUE_W-1:0]  value,
    input  logic [render_pkg::POS_W-1:0]    top,
    input  logic [render_pkg::POS_W-1:0]    left,
    input  logic                            blank_lz,
    output logic                            busy,
    output logic                            done,
    output logic                            dig_start,
    output logic [render_pkg::ADDR_W-1:0]   dig_addr,
    output logic [render_pkg::POS_W-1:0]    dig_top,
    output logic [render_pkg::POS_W-1:0]    dig_left,
    input  logic                            dig_done
);
    import render_pkg::*;

    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int MAX_VAL = 10**DIGITS - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   digit_reg, digit_next;
    logic [POS_W-1:0]   top_reg, top_next;
    logic [POS_W-1:0]   left_reg, left_next;
    logic               blank_reg, blank_next;
    logic               dig_start_reg, dig_start_next;
    logic [ADDR_W-1:0]  dig_addr_reg, dig_addr_next;
    logic [POS_W-1:0]   dig_top_reg, dig_top_next;
    logic [POS_W-1:0]   dig_left_reg, dig_left_next;

    logic [VALUE_W-1:0]        sat_value;
    logic                      conv_start;
    logic                      conv_busy;
    logic                      conv_valid;
    logic [BCD_W*DIGITS-1:0]   bcd;
    logic [BCD_W-1:0]          nib [DIGITS];
    logic [BCD_W-1:0]          cur_nib;
    logic                      lead_zero;
    logic                      skip;

    assign sat_value  = (int'(value) > MAX_VAL) ? VALUE_W'(MAX_VAL) : value;
    assign conv_start = (state_reg == IDLE) && start && !conv_busy;

    bin2bcd_seq #(
        .IN_W   (VALUE_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rstn  (rstn),
        .start (conv_start),
        .din   (sat_value),
        .busy  (conv_busy),
        .valid (conv_valid),
        .bcd   (bcd)
    );

    // nib[0] is the most significant digit, matching the render order.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
            assign nib[gi] = bcd[(DIGITS-1-gi)*BCD_W +: BCD_W];
        end
    endgenerate

    assign cur_nib = nib[digit_reg];

    always_comb begin
        lead_zero = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (k <= int'(digit_reg) && nib[k] != '0) begin
                lead_zero = 1'b0;
            end
        end
    end

    // The last digit is never blanked so that zero still shows a single '0'.
    assign skip = blank_reg && (digit_reg != LAST_IDX) && lead_zero;

    always_comb begin
        state_next     = state_reg;
        digit_next     = digit_reg;
        top_next       = top_reg;
        left_next      = left_reg;
        blank_next     = blank_reg;
        dig_start_next = 1'b0;
        dig_addr_next  = dig_addr_reg;
        dig_top_next   = dig_top_reg;
        dig_left_next  = dig_left_reg;

        case (state_reg)
            IDLE: begin
                if (conv_start) begin
                    top_next   = top;
                    left_next  = left;
                    blank_next = blank_lz;
                    digit_next = '0;
                    state_next = CONV;
                end
            end
            CONV: begin
                if (conv_valid) begin
                    digit_next = '0;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (skip) begin
                    digit_next = digit_reg + 1'b1;
                end else begin
                    dig_start_next = 1'b1;
                    dig_addr_next  = ADDR_W'(int'(cur_nib) * GLYPH_PIX);
                    dig_top_next   = top_reg;
                    dig_left_next  = left_reg + POS_W'(int'(digit_reg) * GLYPH_W);
                    state_next     = WAIT;
                end
            end
            WAIT: begin
                if (dig_done) begin
                    if (digit_reg == LAST_IDX) begin
                        state_next = FIN;
                    end else begin
                        digit_next = digit_reg + 1'b1;
                        state_next = ISSUE;
                    end
                end
            end
            FIN: begin
                digit_next = '0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            digit_reg     <= '0;
            top_reg       <= '0;
            left_reg      <= '0;
            blank_reg     <= 1'b0;
            dig_start_reg <= 1'b0;
            dig_addr_reg  <= '0;
            dig_top_reg   <= '0;
            dig_left_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            digit_reg     <= digit_next;
            top_reg       <= top_next;
            left_reg      <= left_next;
            blank_reg     <= blank_next;
            dig_start_reg <= dig_start_next;
            dig_addr_reg  <= dig_addr_next;
            dig_top_reg   <= dig_top_next;
            dig_left_reg  <= dig_left_next;
        end
    end

    assign busy      = (state_reg != IDLE) && (state_reg != FIN);
    assign done      = (state_reg == FIN);
    assign dig_start = dig_start_reg;
    assign dig_addr  = dig_addr_reg;
    assign dig_top   = dig_top_reg;
    assign dig_left  = dig_left_reg;
endmodule
